// File: rtl/ym_sched_pkg.sv
// Shared types and constants for the YM2151 write scheduler.
package ym_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_A_SETUP,
        ST_A_STB,
        ST_GAP,
        ST_D_SETUP,
        ST_D_STB,
        ST_BUSY
    } sched_state_e;

    localparam logic CS_IDLE = 1'b1;
    localparam logic WR_IDLE = 1'b1;

    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_SETUP_PM   = 1;
    localparam int DEF_STROBE_PM  = 2;
    localparam int DEF_GAP_PM     = 2;
    localparam int DEF_BUSY_PM    = 68;

    // Wide enough for the longest phase (BUSY_PM up to 255).
    localparam int TICK_W = 8;

endpackage

// File: rtl/ym_sched_fifo.sv
// Synchronous FIFO holding {addr,data} write pairs; flush empties it on the same edge.
module ym_sched_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ym_write_sched.sv
// Replays buffered host writes onto the YM2151 bus, paced by ym_pm ticks.
// Optional write counter output enabled by defining YM_WRITE_SCHED_CNT_EN.
module ym_write_sched
    import ym_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int SETUP_PM   = DEF_SETUP_PM,
    parameter int STROBE_PM  = DEF_STROBE_PM,
    parameter int GAP_PM     = DEF_GAP_PM,
    parameter int BUSY_PM    = DEF_BUSY_PM
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ym_pm,
    input  logic                          flush,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [7:0]                    req_addr,
    input  logic [7:0]                    req_data,
    output logic                          ym_cs_n,
    output logic                          ym_wr_n,
    output logic                          ym_a0,
    output logic [7:0]                    ym_dout,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   pending
`ifdef YM_WRITE_SCHED_CNT_EN
    ,
    output logic [15:0]                   wr_count
`endif
);

    localparam logic [TICK_W-1:0] SETUP_L  = TICK_W'(SETUP_PM);
    localparam logic [TICK_W-1:0] STROBE_L = TICK_W'(STROBE_PM);
    localparam logic [TICK_W-1:0] GAP_L    = TICK_W'(GAP_PM);
    localparam logic [TICK_W-1:0] BUSY_L   = TICK_W'(BUSY_PM);

    sched_state_e      state, state_nxt;
    logic [TICK_W-1:0] cnt, cnt_nxt;
    logic              cs_q, cs_nxt;
    logic              wr_q, wr_nxt;
    logic              a0_q, a0_nxt;
    logic [7:0]        dout_q, dout_nxt;
    logic [7:0]        data_q, data_nxt;
    logic              ym_pm_d;
    logic              pm_tick;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [15:0]       fifo_rdata;

    // req_valid/req_ready: a write is taken on every clk where both are high;
    // req_ready never looks at req_valid and drops while flush is asserted.
    assign req_ready = ~fifo_full & ~flush;
    assign pm_tick   = ym_pm & ~ym_pm_d;

    ym_sched_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_valid & req_ready),
        .pop   (pop),
        .flush (flush),
        .wdata ({req_addr, req_data}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (pending)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ym_pm_d <= 1'b0;
            state   <= ST_IDLE;
            cnt     <= '0;
            cs_q    <= CS_IDLE;
            wr_q    <= WR_IDLE;
            a0_q    <= 1'b0;
            dout_q  <= '0;
            data_q  <= '0;
        end else begin
            ym_pm_d <= ym_pm;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            cs_q    <= cs_nxt;
            wr_q    <= wr_nxt;
            a0_q    <= a0_nxt;
            dout_q  <= dout_nxt;
            data_q  <= data_nxt;
        end
    end

    // Each phase reloads cnt on entry and leaves on the tick that finds cnt at 1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cs_nxt    = cs_q;
        wr_nxt    = wr_q;
        a0_nxt    = a0_q;
        dout_nxt  = dout_q;
        data_nxt  = data_q;
        pop       = 1'b0;
        if (pm_tick) begin
            if (state == ST_IDLE) begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    cs_nxt    = 1'b0;
                    wr_nxt    = WR_IDLE;
                    a0_nxt    = 1'b0;
                    dout_nxt  = fifo_rdata[15:8];
                    data_nxt  = fifo_rdata[7:0];
                    state_nxt = ST_A_SETUP;
                    cnt_nxt   = SETUP_L;
                end
            end else if (cnt > TICK_W'(1)) begin
                cnt_nxt = cnt - TICK_W'(1);
            end else begin
                case (state)
                    ST_A_SETUP: begin
                        wr_nxt    = 1'b0;
                        state_nxt = ST_A_STB;
                        cnt_nxt   = STROBE_L;
                    end
                    ST_A_STB: begin
                        wr_nxt    = WR_IDLE;
                        cs_nxt    = CS_IDLE;
                        state_nxt = ST_GAP;
                        cnt_nxt   = GAP_L;
                    end
                    ST_GAP: begin
                        cs_nxt    = 1'b0;
                        a0_nxt    = 1'b1;
                        dout_nxt  = data_q;
                        state_nxt = ST_D_SETUP;
                        cnt_nxt   = SETUP_L;
                    end
                    ST_D_SETUP: begin
                        wr_nxt    = 1'b0;
                        state_nxt = ST_D_STB;
                        cnt_nxt   = STROBE_L;
                    end
                    ST_D_STB: begin
                        wr_nxt    = WR_IDLE;
                        cs_nxt    = CS_IDLE;
                        state_nxt = ST_BUSY;
                        cnt_nxt   = BUSY_L;
                    end
                    default: begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end
                endcase
            end
        end
    end

    assign ym_cs_n = cs_q;
    assign ym_wr_n = wr_q;
    assign ym_a0   = a0_q;
    assign ym_dout = dout_q;
    assign busy    = (state != ST_IDLE);

`ifdef YM_WRITE_SCHED_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
        end else if (pm_tick && state == ST_D_STB && cnt <= TICK_W'(1)) begin
            wr_count <= wr_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ym_write_sched.sv
// Bench for ym_write_sched: decodes the YM bus into write records and checks them.
`timescale 1ns/1ps
module tb_ym_write_sched;

    localparam int S  = 1;
    localparam int B  = 2;
    localparam int G  = 2;
    localparam int BP = 68;
    localparam int SPACING = 2*(S+B) + G + BP + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ym_pm = 1'b0;
    logic       flush = 1'b0;
    logic       req_valid = 1'b0;
    logic [7:0] req_addr = '0;
    logic [7:0] req_data = '0;
    wire        req_ready, ym_cs_n, ym_wr_n, ym_a0, busy;
    wire [7:0]  ym_dout;
    wire [2:0]  pending;
`ifdef YM_WRITE_SCHED_CNT_EN
    wire [15:0] wr_count;
`endif

    always #5 clk = ~clk;

    ym_write_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ym_pm     (ym_pm),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .ym_cs_n   (ym_cs_n),
        .ym_wr_n   (ym_wr_n),
        .ym_a0     (ym_a0),
        .ym_dout   (ym_dout),
        .busy      (busy),
        .pending   (pending)
`ifdef YM_WRITE_SCHED_CNT_EN
        ,
        .wr_count  (wr_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    // ym_pm source: mode 0 runs 2-high/3-low, 1 holds high, 2 holds low.
    int pm_mode  = 0;
    int pm_phase = 4;
    always @(negedge clk) begin
        if (pm_mode == 0) begin
            pm_phase = (pm_phase + 1) % 5;
            ym_pm = (pm_phase < 2);
        end else if (pm_mode == 1) begin
            ym_pm = 1'b1;
        end else begin
            ym_pm = 1'b0;
        end
    end

    // Tick time base: a tick is a clk edge that sees ym_pm newly high.
    int   tick_count = 0;
    logic tb_pm_d = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tb_pm_d <= 1'b0;
        end else begin
            tb_pm_d <= ym_pm;
            if (ym_pm && !tb_pm_d) tick_count <= tick_count + 1;
        end
    end

    typedef struct {
        int         t_cs0, t_wr0, t_r0, t_cs1, t_wr1, t_r1;
        logic [7:0] addr, data;
        logic       a0_a, a0_d, cs_r0_ok, cs_r1_ok;
    } txn_t;

    txn_t        txn_q[$];
    txn_t        cur;
    int          busy_fall_q[$];
    logic [15:0] exp_q[$];
    int          mon_phase = 0;
    int          cs_fall_count = 0;
    int          done_since_reset = 0;
    logic        pc = 1'b1, pw = 1'b1, pb = 1'b0;

    // Bus decoder: address cycle then data cycle, each cs fall / wr fall / rise.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_phase = 0;
            done_since_reset = 0;
            pc = 1'b1; pw = 1'b1; pb = 1'b0;
        end else begin
            if (pc && !ym_cs_n) begin
                cs_fall_count++;
                if (mon_phase == 0) begin cur.t_cs0 = tick_count; mon_phase = 1; end
                else if (mon_phase == 3) begin cur.t_cs1 = tick_count; mon_phase = 4; end
            end
            if (pw && !ym_wr_n) begin
                if (mon_phase == 1) begin
                    cur.t_wr0 = tick_count; cur.addr = ym_dout; cur.a0_a = ym_a0; mon_phase = 2;
                end else if (mon_phase == 4) begin
                    cur.t_wr1 = tick_count; cur.data = ym_dout; cur.a0_d = ym_a0; mon_phase = 5;
                end
            end
            if (!pw && ym_wr_n) begin
                if (mon_phase == 2) begin
                    cur.t_r0 = tick_count; cur.cs_r0_ok = ym_cs_n; mon_phase = 3;
                end else if (mon_phase == 5) begin
                    cur.t_r1 = tick_count; cur.cs_r1_ok = ym_cs_n; mon_phase = 0;
                    txn_q.push_back(cur);
                    done_since_reset++;
                end
            end
            if (pb && !busy) busy_fall_q.push_back(tick_count);
            pc = ym_cs_n; pw = ym_wr_n; pb = busy;
        end
    end

    task automatic push_one(input logic [7:0] a, input logic [7:0] d, output int waited);
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_data = d; waited = 0;
        #1;
        while (!req_ready && waited < 2000) begin
            @(negedge clk); #1; waited++;
        end
        total++;
        if (!req_ready) begin
            bad++;
            $display("FAIL push_timeout ready=%b want=1 after %0d clks", req_ready, waited);
        end else begin
            @(posedge clk);
            exp_q.push_back({a, d});
        end
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        int c = 0;
        @(negedge clk); #1;
        while (!(txn_q.size() >= n && !busy && pending == 0) && c < budget) begin
            @(negedge clk); #1; c++;
        end
        total++;
        if (c >= budget) begin
            bad++;
            $display("FAIL wait_done txns=%0d want=%0d busy=%b", txn_q.size(), n, busy);
        end
    endtask

    task automatic wait_txn(input int n, input int budget);
        int c = 0;
        while (txn_q.size() < n && c < budget) begin
            @(negedge clk); #1; c++;
        end
        total++;
        if (c >= budget) begin
            bad++;
            $display("FAIL wait_txn txns=%0d want=%0d", txn_q.size(), n);
        end
    endtask

    task automatic clear_books();
        txn_q.delete(); busy_fall_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (ym_cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n got=%b want=1", ym_cs_n); end
        total++; if (ym_wr_n !== 1'b1) begin bad++; $display("FAIL reset_wr_n got=%b want=1", ym_wr_n); end
        total++; if (ym_a0 !== 1'b0) begin bad++; $display("FAIL reset_a0 got=%b want=0", ym_a0); end
        total++; if (ym_dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h want=00", ym_dout); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (pending !== 3'd0) begin bad++; $display("FAIL reset_pending got=%0d want=0", pending); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
        @(negedge clk); rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        total++; if (busy !== 1'b0 || ym_cs_n !== 1'b1) begin bad++; $display("FAIL reset_idle busy=%b cs_n=%b want 0/1", busy, ym_cs_n); end
    endtask

    task automatic test_single();
        txn_t t;
        int   w, bf;
        clear_books();
        push_one(8'h20, 8'hC7, w);
        wait_done(1, 3000);
        t = txn_q.size() > 0 ? txn_q[0] : '{default: 0};
        bf = busy_fall_q.size() > 0 ? busy_fall_q[$] : -1;
        total++; if (t.addr !== 8'h20 || t.a0_a !== 1'b0) begin bad++; $display("FAIL single_addr got=%h/a0=%b want=20/0", t.addr, t.a0_a); end
        total++; if (t.data !== 8'hC7 || t.a0_d !== 1'b1) begin bad++; $display("FAIL single_data got=%h/a0=%b want=c7/1", t.data, t.a0_d); end
        total++; if (t.t_wr0 - t.t_cs0 != S) begin bad++; $display("FAIL single_T1 got=%0d want=%0d", t.t_wr0 - t.t_cs0, S); end
        total++; if (t.t_r0 - t.t_cs0 != S+B || t.cs_r0_ok !== 1'b1) begin bad++; $display("FAIL single_T3 got=%0d cs=%b want=%0d", t.t_r0 - t.t_cs0, t.cs_r0_ok, S+B); end
        total++; if (t.t_cs1 - t.t_cs0 != S+B+G) begin bad++; $display("FAIL single_T5 got=%0d want=%0d", t.t_cs1 - t.t_cs0, S+B+G); end
        total++; if (t.t_wr1 - t.t_cs0 != 2*S+B+G) begin bad++; $display("FAIL single_T6 got=%0d want=%0d", t.t_wr1 - t.t_cs0, 2*S+B+G); end
        total++; if (t.t_r1 - t.t_cs0 != 2*(S+B)+G || t.cs_r1_ok !== 1'b1) begin bad++; $display("FAIL single_T8 got=%0d cs=%b want=%0d", t.t_r1 - t.t_cs0, t.cs_r1_ok, 2*(S+B)+G); end
        total++; if (bf - t.t_cs0 != 2*(S+B)+G+BP) begin bad++; $display("FAIL single_idle got=%0d want=%0d", bf - t.t_cs0, 2*(S+B)+G+BP); end
    endtask

    task automatic test_back_to_back();
        int w;
        clear_books();
        pm_mode = 2;
        for (int i = 0; i < 3; i++) push_one(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), w);
        @(negedge clk); #1;
        total++; if (pending !== 3'd3) begin bad++; $display("FAIL b2b_pending got=%0d want=3", pending); end
        pm_mode = 0;
        wait_done(3, 5000);
        for (int i = 0; i < 3 && i < txn_q.size(); i++) begin
            total++;
            if ({txn_q[i].addr, txn_q[i].data} !== exp_q[i]) begin
                bad++; $display("FAIL b2b_order[%0d] got=%h want=%h", i, {txn_q[i].addr, txn_q[i].data}, exp_q[i]);
            end
            if (i > 0) begin
                total++;
                if (txn_q[i].t_cs0 - txn_q[i-1].t_cs0 != SPACING) begin
                    bad++; $display("FAIL b2b_spacing[%0d] got=%0d want=%0d", i, txn_q[i].t_cs0 - txn_q[i-1].t_cs0, SPACING);
                end
            end
        end
    endtask

    task automatic test_full();
        int w;
        clear_books();
        push_one(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), w);
        wait_txn(1, 3000);
        for (int i = 0; i < 4; i++) push_one(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), w);
        @(negedge clk); #1;
        total++; if (pending !== 3'd4) begin bad++; $display("FAIL full_pending got=%0d want=4", pending); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", req_ready); end
        push_one(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), w);
        total++; if (w < 50) begin bad++; $display("FAIL full_holdoff waited=%0d want>=50", w); end
        wait_done(6, 12000);
        for (int i = 0; i < 6 && i < txn_q.size(); i++) begin
            total++;
            if ({txn_q[i].addr, txn_q[i].data} !== exp_q[i]) begin
                bad++; $display("FAIL full_order[%0d] got=%h want=%h", i, {txn_q[i].addr, txn_q[i].data}, exp_q[i]);
            end
        end
    endtask

    task automatic test_flush();
        int   w, c, cs_before;
        logic [15:0] first;
        clear_books();
        pm_mode = 2;
        for (int i = 0; i < 3; i++) push_one(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), w);
        first = exp_q[0];
        pm_mode = 0;
        wait_txn(1, 3000);
        total++; if (pending !== 3'd2) begin bad++; $display("FAIL flush_pre_pending got=%0d want=2", pending); end
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1;
        req_addr = 8'($urandom_range(0, 255)); req_data = 8'($urandom_range(0, 255));
        #1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want=0", req_ready); end
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clk); #1;
        total++; if (pending !== 3'd0) begin bad++; $display("FAIL flush_pending got=%0d want=0", pending); end
        c = 0;
        while (busy && c < 2000) begin @(negedge clk); #1; c++; end
        total++;
        if (busy_fall_q.size() == 0 || txn_q.size() == 0 || busy_fall_q[$] - txn_q[0].t_cs0 != 2*(S+B)+G+BP) begin
            bad++; $display("FAIL flush_idle_time falls=%0d want busy low at T%0d", busy_fall_q.size(), 2*(S+B)+G+BP);
        end
        total++; if (txn_q.size() > 0 && {txn_q[0].addr, txn_q[0].data} !== first) begin bad++; $display("FAIL flush_write1 got=%h want=%h", {txn_q[0].addr, txn_q[0].data}, first); end
        cs_before = cs_fall_count;
        repeat (300) @(negedge clk);
        #1;
        total++; if (cs_fall_count != cs_before || txn_q.size() != 1 || busy !== 1'b0) begin
            bad++; $display("FAIL flush_quiet cs_falls=%0d txns=%0d want 0 extra/1", cs_fall_count - cs_before, txn_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int w, c;
        clear_books();
        pm_mode = 2;
        push_one(8'($urandom_range(0, 127)) | 8'h01, 8'($urandom_range(0, 255)), w);
        push_one(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), w);
        pm_mode = 0;
        c = 0;
        while (ym_wr_n !== 1'b0 && c < 1000) begin @(negedge clk); #1; c++; end
        total++; if (ym_wr_n !== 1'b0) begin bad++; $display("FAIL rstmid_strobe wr_n=%b want=0", ym_wr_n); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (ym_cs_n !== 1'b1 || ym_wr_n !== 1'b1) begin bad++; $display("FAIL rstmid_async cs_n=%b wr_n=%b want=1/1", ym_cs_n, ym_wr_n); end
        total++; if (ym_a0 !== 1'b0 || ym_dout !== 8'h00) begin bad++; $display("FAIL rstmid_bus a0=%b dout=%h want=0/00", ym_a0, ym_dout); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (pending !== 3'd0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_release pending=%0d busy=%b want=0/0", pending, busy); end
        repeat (40) @(negedge clk);
        #1;
        total++; if (busy !== 1'b0 || ym_cs_n !== 1'b1) begin bad++; $display("FAIL rstmid_idle busy=%b cs_n=%b want=0/1", busy, ym_cs_n); end
        clear_books();
    endtask

    task automatic test_stall();
        int w, c, t_before, stall_bad;
        clear_books();
        push_one(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), w);
        c = 0;
        while (mon_phase != 2 && c < 1000) begin @(negedge clk); #1; c++; end
        pm_mode = 1;
        t_before = tick_count;
        stall_bad = 0;
        repeat (100) begin
            @(negedge clk); #1;
            if (ym_wr_n !== 1'b0 || ym_cs_n !== 1'b0 || busy !== 1'b1) stall_bad++;
        end
        total++; if (stall_bad != 0) begin bad++; $display("FAIL stall_hold bad_samples=%0d want=0", stall_bad); end
        total++; if (tick_count != t_before) begin bad++; $display("FAIL stall_ticks got=%0d want=%0d", tick_count, t_before); end
        pm_mode = 0;
        wait_done(1, 3000);
        if (txn_q.size() > 0) begin
            total++; if (txn_q[0].t_r0 - txn_q[0].t_wr0 != B) begin bad++; $display("FAIL stall_resume got=%0d want=%0d", txn_q[0].t_r0 - txn_q[0].t_wr0, B); end
            total++; if (txn_q[0].t_r1 - txn_q[0].t_cs0 != 2*(S+B)+G) begin bad++; $display("FAIL stall_T8 got=%0d want=%0d", txn_q[0].t_r1 - txn_q[0].t_cs0, 2*(S+B)+G); end
            total++; if ({txn_q[0].addr, txn_q[0].data} !== exp_q[0]) begin bad++; $display("FAIL stall_data got=%h want=%h", {txn_q[0].addr, txn_q[0].data}, exp_q[0]); end
        end
    endtask

    task automatic test_random();
        int w;
        clear_books();
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(0, 150)) @(negedge clk);
            push_one(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), w);
        end
        wait_done(6, 20000);
        for (int i = 0; i < 6 && i < txn_q.size(); i++) begin
            total++;
            if ({txn_q[i].addr, txn_q[i].data} !== exp_q[i] || txn_q[i].a0_a !== 1'b0 || txn_q[i].a0_d !== 1'b1) begin
                bad++; $display("FAIL rand_order[%0d] got=%h want=%h", i, {txn_q[i].addr, txn_q[i].data}, exp_q[i]);
            end
            if (i > 0) begin
                total++;
                if (txn_q[i].t_cs0 - txn_q[i-1].t_cs0 < SPACING) begin
                    bad++; $display("FAIL rand_spacing[%0d] got=%0d want>=%0d", i, txn_q[i].t_cs0 - txn_q[i-1].t_cs0, SPACING);
                end
            end
        end
`ifdef YM_WRITE_SCHED_CNT_EN
        total++;
        if (wr_count !== 16'(done_since_reset)) begin
            bad++; $display("FAIL wr_count got=%0d want=%0d", wr_count, done_since_reset);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_flush();
        test_reset_mid();
        test_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
